counter_bank: RTL and testbench

Parametrised bank of independent up/down counters sharing one clock domain. It is the next generation of the fixed 8-bit free-running counter. It adds per-channel enable, direction, synchronous load and clear, a wrap or saturate mode, terminal-count pulses, sticky overflow flags, and a coherent snapshot of all channels. It is used wherever several event or cycle counters must be read back consistently by a status/CSR block.

---
 rtl/counter_bank_if.sv | 29 ++
 rtl/counter_bank.sv | 89 ++++++++
 tb/tb_counter_bank.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_bank_if.sv
// Signal bundle between a counter_bank and its controlling/status logic.
// The master side drives the per-channel controls; the slave side is the counter bank.
interface counter_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS-1:0]       ovf_clr;
    logic                      snap;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       tc;
    logic [CHANNELS-1:0]       ovf;
    logic [CHANNELS*WIDTH-1:0] snap_count;
    logic                      snap_valid;

    modport master (
        output en, dir, load, load_val, clear, ovf_clr, snap,
        input  count, tc, ovf, snap_count, snap_valid
    );

    modport slave (
        input  en, dir, load, load_val, clear, ovf_clr, snap,
        output count, tc, ovf, snap_count, snap_valid
    );
endinterface

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with wrap or saturate boundary handling,
// terminal-count pulses, sticky overflow flags and a coherent all-channel snapshot.
module counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic           clk,
    input  logic           reset,
    counter_bank_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT_MODE = (SATURATE != 32'sd0);

    logic [CHANNELS*WIDTH-1:0] count_r;
    logic [CHANNELS*WIDTH-1:0] count_nxt_s;
    logic [CHANNELS*WIDTH-1:0] snap_count_r;
    logic [CHANNELS-1:0]       tc_r;
    logic [CHANNELS-1:0]       tc_nxt_s;
    logic [CHANNELS-1:0]       ovf_r;
    logic [CHANNELS-1:0]       ovf_nxt_s;
    logic                      snap_valid_r;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cur_s;
        logic [WIDTH-1:0] term_s;
        logic [WIDTH-1:0] step_s;
        logic [WIDTH-1:0] nxt_s;
        logic             boundary_s;

        // Per-channel next value: clear beats load beats step; a step from the
        // terminal value either wraps (natural modulo step) or holds.
        always_comb begin
            cur_s      = count_r[i*WIDTH +: WIDTH];
            term_s     = bus.dir[i] ? MAX_VAL : ZERO_VAL;
            step_s     = bus.dir[i] ? (cur_s + ONE_VAL) : (cur_s - ONE_VAL);
            boundary_s = 1'b0;
            nxt_s      = cur_s;
            if (bus.clear[i]) begin
                nxt_s = ZERO_VAL;
            end else if (bus.load[i]) begin
                nxt_s = bus.load_val[i*WIDTH +: WIDTH];
            end else if (bus.en[i]) begin
                if (cur_s == term_s) begin
                    boundary_s = 1'b1;
                    nxt_s      = SAT_MODE ? cur_s : step_s;
                end else begin
                    nxt_s = step_s;
                end
            end else begin
                nxt_s = cur_s;
            end
        end

        assign count_nxt_s[i*WIDTH +: WIDTH] = nxt_s;
        assign tc_nxt_s[i]  = boundary_s;
        // Setting the sticky flag takes precedence over a same-cycle clear.
        assign ovf_nxt_s[i] = boundary_s | (ovf_r[i] & ~bus.ovf_clr[i]);
    end

    // State and output registers; the snapshot captures pre-update counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r      <= {(CHANNELS*WIDTH){1'b0}};
            tc_r         <= {CHANNELS{1'b0}};
            ovf_r        <= {CHANNELS{1'b0}};
            snap_count_r <= {(CHANNELS*WIDTH){1'b0}};
            snap_valid_r <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            tc_r         <= tc_nxt_s;
            ovf_r        <= ovf_nxt_s;
            snap_valid_r <= bus.snap;
            if (bus.snap) begin
                snap_count_r <= count_r;
            end else begin
                snap_count_r <= snap_count_r;
            end
        end
    end

    assign bus.count      = count_r;
    assign bus.tc         = tc_r;
    assign bus.ovf        = ovf_r;
    assign bus.snap_count = snap_count_r;
    assign bus.snap_valid = snap_valid_r;
endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter_bank share stimulus,
// and an integer reference model predicts every post-edge output set.
module tb_counter_bank;
    localparam int W = 8;
    localparam int C = 4;

    typedef struct {
        logic [C*W-1:0] count;
        logic [C-1:0]   tc;
        logic [C-1:0]   ovf;
        logic [C*W-1:0] snap_count;
        logic           snap_valid;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [C-1:0]   en_v = '0, dir_v = '0, load_v = '0, clear_v = '0, oc_v = '0;
    logic [C*W-1:0] lv_v = '0;
    logic           snap_v = 1'b0;

    int total = 0;
    int bad = 0;

    exp_t q_w[$];
    exp_t q_s[$];

    int mcnt [2][C];
    bit mtc  [2][C];
    bit movf [2][C];
    int msnap[2][C];
    bit msv  [2];

    always #5 clk = ~clk;

    counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bw ();
    counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bs ();

    assign bw.en = en_v;   assign bw.dir = dir_v;     assign bw.load = load_v;
    assign bw.clear = clear_v; assign bw.ovf_clr = oc_v; assign bw.load_val = lv_v;
    assign bw.snap = snap_v;
    assign bs.en = en_v;   assign bs.dir = dir_v;     assign bs.load = load_v;
    assign bs.clear = clear_v; assign bs.ovf_clr = oc_v; assign bs.load_val = lv_v;
    assign bs.snap = snap_v;

    counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(0)) u_wrap (.clk(clk), .reset(reset), .bus(bw));
    counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(1)) u_sat  (.clk(clk), .reset(reset), .bus(bs));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            msv[m] = 1'b0;
            for (int ch = 0; ch < C; ch++) begin
                mcnt[m][ch] = 0; mtc[m][ch] = 1'b0; movf[m][ch] = 1'b0; msnap[m][ch] = 0;
            end
        end
    endtask

    // Reference behaviour of one edge for mode m (0 = wrap, 1 = saturate).
    task automatic model_step(input int m, output exp_t e);
        int maxv;
        int c;
        bit bnd;
        maxv = (1 << W) - 1;
        if (snap_v)
            for (int ch = 0; ch < C; ch++) msnap[m][ch] = mcnt[m][ch];
        msv[m] = snap_v;
        for (int ch = 0; ch < C; ch++) begin
            c = mcnt[m][ch];
            bnd = 1'b0;
            if (clear_v[ch]) c = 0;
            else if (load_v[ch]) c = int'(lv_v[ch*W +: W]);
            else if (en_v[ch]) begin
                if (dir_v[ch]) begin
                    if (c == maxv) begin bnd = 1'b1; c = (m == 1) ? maxv : 0; end
                    else c = c + 1;
                end else begin
                    if (c == 0) begin bnd = 1'b1; c = (m == 1) ? 0 : maxv; end
                    else c = c - 1;
                end
            end
            mcnt[m][ch] = c;
            mtc[m][ch] = bnd;
            if (bnd) movf[m][ch] = 1'b1;
            else if (oc_v[ch]) movf[m][ch] = 1'b0;
        end
        for (int ch = 0; ch < C; ch++) begin
            e.count[ch*W +: W]      = W'(mcnt[m][ch]);
            e.snap_count[ch*W +: W] = W'(msnap[m][ch]);
            e.tc[ch]  = mtc[m][ch];
            e.ovf[ch] = movf[m][ch];
        end
        e.snap_valid = msv[m];
    endtask

    task automatic drive(input logic [C-1:0] en_i, input logic [C-1:0] dir_i,
                         input logic [C-1:0] load_i, input logic [C-1:0] clear_i,
                         input logic [C-1:0] oc_i, input logic snap_i,
                         input logic [C*W-1:0] lv_i);
        exp_t e;
        @(negedge clk);
        en_v = en_i; dir_v = dir_i; load_v = load_i; clear_v = clear_i;
        oc_v = oc_i; snap_v = snap_i; lv_v = lv_i;
        model_step(0, e); q_w.push_back(e);
        model_step(1, e); q_s.push_back(e);
    endtask

    task automatic cmp_exp(input string tag, input exp_t e, input logic [C*W-1:0] cnt,
                           input logic [C-1:0] tc, input logic [C-1:0] ovf,
                           input logic [C*W-1:0] sc, input logic sv);
        chk({tag, ".count"}, 64'(cnt), 64'(e.count));
        chk({tag, ".tc"}, 64'(tc), 64'(e.tc));
        chk({tag, ".ovf"}, 64'(ovf), 64'(e.ovf));
        chk({tag, ".snap_valid"}, 64'(sv), 64'(e.snap_valid));
        if (e.snap_valid) chk({tag, ".snap_count"}, 64'(sc), 64'(e.snap_count));
    endtask

    // Monitor: one predicted output set is retired per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                cmp_exp("wrap", e, bw.count, bw.tc, bw.ovf, bw.snap_count, bw.snap_valid);
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                cmp_exp("sat", e, bs.count, bs.tc, bs.ovf, bs.snap_count, bs.snap_valid);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C-1:0]   r_en, r_dir, r_ld, r_clr, r_oc;
        logic [C*W-1:0] r_lv;
        logic [W-1:0]   pick;
        int budget;

        model_reset();
        #3;
        chk("rst.count", 64'(bw.count | bs.count), 64'd0);
        chk("rst.tc", 64'(bw.tc | bs.tc), 64'd0);
        chk("rst.ovf", 64'(bw.ovf | bs.ovf), 64'd0);
        chk("rst.snap_count", 64'(bw.snap_count | bs.snap_count), 64'd0);
        chk("rst.snap_valid", 64'(bw.snap_valid | bs.snap_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized phase, loads biased towards the boundaries.
        for (int n = 0; n < 400; n++) begin
            r_en = '0; r_dir = '0; r_ld = '0; r_clr = '0; r_oc = '0; r_lv = '0;
            for (int ch = 0; ch < C; ch++) begin
                r_en[ch]  = ($urandom_range(0, 3) != 0);
                r_dir[ch] = ($urandom_range(0, 1) == 1);
                r_ld[ch]  = ($urandom_range(0, 9) == 0);
                r_clr[ch] = ($urandom_range(0, 19) == 0);
                r_oc[ch]  = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 4))
                    0: pick = 8'h00;
                    1: pick = 8'h01;
                    2: pick = 8'hFE;
                    3: pick = 8'hFF;
                    default: pick = W'($urandom);
                endcase
                r_lv[ch*W +: W] = pick;
            end
            drive(r_en, r_dir, r_ld, r_clr, r_oc, ($urandom_range(0, 3) == 0), r_lv);
        end
        drive(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, '0);

        // Wrap up on ch0.
        drive(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 32'h0000_00FE);
        drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        @(posedge clk); #1;
        chk("wrap1.count0", 64'(bw.count[7:0]), 64'hFF);
        chk("wrap1.tc0", 64'(bw.tc[0]), 64'd0);
        drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        @(posedge clk); #1;
        chk("wrap2.count0", 64'(bw.count[7:0]), 64'h00);
        chk("wrap2.tc0", 64'(bw.tc[0]), 64'd1);
        drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        @(posedge clk); #1;
        chk("wrap3.count0", 64'(bw.count[7:0]), 64'h01);
        chk("wrap3.tc0", 64'(bw.tc[0]), 64'd0);
        chk("wrap3.ovf0", 64'(bw.ovf[0]), 64'd1);

        // Saturate down on ch2.
        drive(4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0, 32'h0001_0000);
        for (int k = 0; k < 3; k++) begin
            drive(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, '0);
            @(posedge clk); #1;
            chk("satdn.count2", 64'(bs.count[23:16]), 64'h00);
            chk("satdn.tc2", 64'(bs.tc[2]), (k == 0) ? 64'd0 : 64'd1);
        end

        // Priority on ch1: clear > load > enable.
        drive(4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 1'b0, 32'h0000_5500);
        @(posedge clk); #1;
        chk("prio.clear", 64'(bw.count[15:8]), 64'h00);
        drive(4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 1'b0, 32'h0000_5500);
        @(posedge clk); #1;
        chk("prio.load", 64'(bs.count[15:8]), 64'h55);

        // Snapshot coherence.
        drive(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, {8'd40, 8'd30, 8'd20, 8'd10});
        repeat (3) drive(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        drive(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, '0);
        @(posedge clk); #1;
        chk("snap.snap_count", 64'(bw.snap_count), 64'({8'd43, 8'd33, 8'd23, 8'd13}));
        chk("snap.count", 64'(bw.count), 64'({8'd44, 8'd34, 8'd24, 8'd14}));
        chk("snap.valid", 64'(bw.snap_valid), 64'd1);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        @(posedge clk); #1;
        chk("snap.valid_drop", 64'(bw.snap_valid), 64'd0);

        // Overflow set/clear race on ch3.
        drive(4'h0, 4'h0, 4'h8, 4'h0, 4'h8, 1'b0, 32'hFF00_0000);
        drive(4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 1'b0, '0);
        @(posedge clk); #1;
        chk("ovfrace.set_wins", 64'(bw.ovf[3]), 64'd1);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0, '0);
        @(posedge clk); #1;
        chk("ovfrace.cleared", 64'(bw.ovf[3]), 64'd0);

        // Asynchronous reset with tc and snap_valid in flight.
        drive(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 32'h0000_00FF);
        drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, '0);
        @(posedge clk); #1;
        chk("arst.pre_tc", 64'(bw.tc[0]), 64'd1);
        chk("arst.pre_sv", 64'(bw.snap_valid), 64'd1);
        #1;
        reset = 1'b0;
        en_v = '0; dir_v = '0; load_v = '0; clear_v = '0; oc_v = '0; snap_v = 1'b0; lv_v = '0;
        #1;
        chk("arst.count", 64'(bw.count | bs.count), 64'd0);
        chk("arst.tc", 64'(bw.tc | bs.tc), 64'd0);
        chk("arst.ovf", 64'(bw.ovf | bs.ovf), 64'd0);
        chk("arst.snap_count", 64'(bw.snap_count | bs.snap_count), 64'd0);
        chk("arst.snap_valid", 64'(bw.snap_valid | bs.snap_valid), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, '0);
        @(posedge clk); #1;
        chk("arst.first_count", 64'(bw.count[7:0]), 64'h01);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, '0);

        budget = 20;
        while ((q_w.size() > 0 || q_s.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        chk("drain.pending", 64'(q_w.size() + q_s.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
